// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display controller: bus address,
// blank pattern and the active-low hex-to-segment table.
package seg7_pkg;

  localparam logic [31:0] SEG7_ADDR = 32'h1001_0000;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  typedef logic [2:0] digit_idx_t;

  // Active-low {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg7_ctrl.sv
// Memory-mapped 8-digit seven-segment controller: latches a 32-bit word on store
// and scans its eight hex nibbles across common-anode digits.
module seg7_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 100000,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seg7_cs,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned PreW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(CLK_DIV - 1);

  logic [31:0]     data_q;
  logic [PreW-1:0] pre_q;
  logic            tick;
  digit_idx_t      digit_q;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      nibble;
  logic [6:0]      dec_seg;
  logic            leading_zero;

  assign tick = (pre_q == PreMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      pre_q   <= '0;
      digit_q <= '0;
      an_q    <= 8'hFF;
      seg_q   <= SEG_BLANK;
    end else begin
      if (seg7_cs && we) begin
        data_q <= wdata;
      end
      pre_q <= tick ? '0 : pre_q + 1'b1;
      // 3-bit index wraps 7 -> 0 on its own.
      if (tick) begin
        digit_q <= digit_q + 3'd1;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  always_comb begin
    nibble       = data_q[{digit_q, 2'b00} +: 4];
    // Digit 0 is never blanked so a zero value still shows "0".
    leading_zero = (digit_q != 3'd0) && ((data_q >> {digit_q, 2'b00}) == 32'h0);
    an_d         = ~(8'b1 << digit_q);
    seg_d        = (BLANK_LZ && leading_zero) ? SEG_BLANK : dec_seg;
  end

  seg7_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  assign rdata = seg7_cs ? data_q : 32'h0;
  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = 1'b1;

endmodule

// File: tb/tb_seg7_ctrl.sv
// Scoreboard bench for seg7_ctrl: a cycle-counting reference model predicts each
// displayed digit; a negedge monitor pops and compares both blanking variants.
module tb_seg7_ctrl;

  localparam int unsigned ClkDiv = 4;

  logic        clk;
  logic        rst_n;
  logic        seg7_cs;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata0, rdata1;
  logic [7:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;

  seg7_ctrl #(.CLK_DIV(ClkDiv), .BLANK_LZ(1'b0)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg7_cs (seg7_cs),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata0),
    .an      (an0),
    .seg     (seg0),
    .dp      (dp0)
  );

  seg7_ctrl #(.CLK_DIV(ClkDiv), .BLANK_LZ(1'b1)) u_dut_lz (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg7_cs (seg7_cs),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata1),
    .an      (an1),
    .seg     (seg1),
    .dp      (dp1)
  );

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg_plain;
    logic [6:0] seg_lz;
  } exp_t;

  logic [6:0] hex_tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          edges    = 0;   // edges since reset release
  logic [31:0] mdata    = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference model: the digit shown after an edge is the one selected by the
  // number of whole CLK_DIV slots completed before that edge.
  initial begin
    exp_t e;
    int   d;
    logic [31:0] upper;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        edges = 0;
        mdata = 32'h0;
      end else begin
        d           = (edges / ClkDiv) % 8;
        upper       = mdata >> (4 * d);
        e.an        = ~(8'h01 << d);
        e.seg_plain = hex_tbl[upper[3:0]];
        e.seg_lz    = (d != 0 && upper == 32'h0) ? 7'h7F : e.seg_plain;
        sb.push_back(e);
        if (seg7_cs && we) mdata = wdata;
        edges++;
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        chk("rst_an", {24'h0, an0}, 32'hFF);
        chk("rst_seg", {25'h0, seg0}, 32'h7F);
        chk("rst_seg_lz", {25'h0, seg1}, 32'h7F);
        chk("rst_dp", {31'h0, dp0}, 32'h1);
        chk("rst_rdata", rdata0, 32'h0);
      end else if (sb.size() == 0) begin
        chk("no_expected_output", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("an", {24'h0, an0}, {24'h0, e.an});
        chk("an_lz", {24'h0, an1}, {24'h0, e.an});
        chk("seg", {25'h0, seg0}, {25'h0, e.seg_plain});
        chk("seg_lz", {25'h0, seg1}, {25'h0, e.seg_lz});
        chk("dp", {31'h0, dp0 & dp1}, 32'h1);
        chk("rdata", rdata0, seg7_cs ? mdata : 32'h0);
        chk("rdata_lz", rdata1, seg7_cs ? mdata : 32'h0);
      end
    end
  end

  task automatic cycle(input logic cs, input logic w, input logic [31:0] d);
    @(posedge clk);
    #1;
    seg7_cs = cs;
    we      = w;
    wdata   = d;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    int          guard;
    rst_n   = 1'b0;
    seg7_cs = 1'b0;
    we      = 1'b0;
    wdata   = 32'h0;
    repeat (3) @(posedge clk);
    release_reset();

    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h89AB_CDEF);
    repeat (40) cycle(1'b1, 1'b0, 32'h0);

    repeat (5) cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    cycle(1'b1, 1'b1, 32'h0000_0120);
    repeat (36) cycle(1'($urandom_range(1)), 1'b0, 32'h0);

    for (int i = 0; i < 200; i++) begin
      r = $urandom() >> $urandom_range(31);
      cycle(1'($urandom_range(1)), ($urandom_range(9) == 0), r);
    end

    // Wait until digit 5 is being scanned, then reset mid-slot.
    guard = 0;
    cycle(1'b1, 1'b0, 32'h0);
    while (((edges / ClkDiv) % 8) != 5 && guard < 100) begin
      cycle(1'b1, 1'b0, 32'h0);
      guard++;
    end
    if (guard >= 100) chk("reach_digit5", 32'h0, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_an", {24'h0, an0}, 32'hFF);
    chk("async_seg", {25'h0, seg0}, 32'h7F);
    chk("async_seg_lz", {25'h0, seg1}, 32'h7F);
    chk("async_rdata", rdata0, 32'h0);
    repeat (2) @(posedge clk);
    release_reset();
    repeat (40) cycle(1'b1, 1'b0, 32'h0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
